fp16_mult_scheduler: RTL

Shares one pipelined FP16 multiplier (`FPMult_16` plus its external 11x11 mantissa DSP multiplier) among `NUM_REQ` requesters. Uses round-robin arbitration, a tag pipeline that tracks in-flight operations, and a credit-protected response FIFO, so a stalled consumer never loses a product. It sits between the requesting compute lanes and the multiplier instance.

---
 rtl/fp16_mult_pkg.sv | 25 ++
 rtl/fp16_mult_scheduler_rr_arbiter.sv | 33 +++
 rtl/fp16_mult_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fp16_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_mult_pkg
//  Purpose  : Shared widths and the response-FIFO entry type for the FP16
//             multiplier scheduler.
//  Contents : FP16_W   - FP16 operand/result width
//             FLAG_W   - multiplier exception flag width
//             ID_MAX_W - id field width, enough for up to 8 requesters
//             rsp_entry_t {id, result, flags}
//  Revision : 1.0 - initial release
// ============================================================================
package fp16_mult_pkg;

    localparam int FP16_W   = 16;
    localparam int FLAG_W   = 5;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [FP16_W-1:0]   result;
        logic [FLAG_W-1:0]   flags;
    } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/fp16_mult_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin grant. The grant goes to the first
//             asserted request at or after ptr, wrapping around.
//  Ports    : req [N-1:0]          - request vector
//             ptr [clog2(N)-1:0]   - highest-priority index (must be < N)
//             gnt [N-1:0]          - one-hot grant, zero when no request
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_rotGnt;
    logic [2*N-1:0] w_gntDbl;

    // Rotate so that ptr lands on bit 0, isolate the lowest set bit, then
    // rotate back by folding the doubled vector.
    always_comb begin
        w_rot    = N'({req, req} >> ptr);
        w_rotGnt = w_rot & (~w_rot + N'(1));
        w_gntDbl = {{N{1'b0}}, w_rotGnt} << ptr;
        gnt      = w_gntDbl[N-1:0] | w_gntDbl[2*N-1:N];
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mult_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_mult_scheduler
//  Purpose  : Shares one pipelined FP16 multiplier among NUM_REQ requesters
//             with round-robin arbitration, an in-flight tag pipeline and a
//             credit-protected response FIFO.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready [NUM_REQ]     - per-requester handshake
//             req_a/req_b [16*NUM_REQ]          - packed operands
//             mul_issue, mul_a, mul_b           - to the multiplier
//             mul_result, mul_flags             - from the multiplier
//             rsp_valid/rsp_ready               - response handshake
//             rsp_id, rsp_result, rsp_flags     - response payload (FIFO head)
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_mult_scheduler
    import fp16_mult_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [FP16_W*NUM_REQ-1:0]  req_a,
    input  logic [FP16_W*NUM_REQ-1:0]  req_b,
    output logic                       mul_issue,
    output logic [FP16_W-1:0]          mul_a,
    output logic [FP16_W-1:0]          mul_b,
    input  logic [FP16_W-1:0]          mul_result,
    input  logic [FLAG_W-1:0]          mul_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [FP16_W-1:0]          rsp_result,
    output logic [FLAG_W-1:0]          rsp_flags
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [c_ID_W-1:0]      r_ptr;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]     w_gnt;
    logic                   w_canIssue;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [c_ID_W-1:0]      w_gntIdx;
    logic [FP16_W-1:0]      w_selA;
    logic [FP16_W-1:0]      w_selB;

    logic                   r_mulIssue;
    logic [FP16_W-1:0]      r_mulA;
    logic [FP16_W-1:0]      r_mulB;
    logic [c_ID_W-1:0]      r_issueId;

    logic [MUL_LATENCY-1:0] r_tagValid;
    logic [c_ID_W-1:0]      r_tagId [MUL_LATENCY];

    rsp_entry_t             r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]        r_wrPtr;
    logic [c_AW-1:0]        r_rdPtr;
    logic [c_CNT_W-1:0]     r_fifoCnt;
    rsp_entry_t             w_pushEntry;
    rsp_entry_t             w_head;
    logic                   w_unusedIdBits;

    // ------------------------------------------------------------------
    // Arbitration and credit gating
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    // cnt covers everything already accepted but not yet popped, so a
    // credit guarantees a FIFO slot when the product finally arrives.
    assign w_canIssue = (r_cnt < c_CNT_W'(FIFO_DEPTH));
    assign req_ready  = rst ? '0 : (w_gnt & {NUM_REQ{w_canIssue}});
    assign w_accept   = |req_ready;

    always_comb begin
        w_gntIdx = '0;
        w_selA   = '0;
        w_selB   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gntIdx = c_ID_W'(i);
                w_selA   = req_a[FP16_W*i +: FP16_W];
                w_selB   = req_b[FP16_W*i +: FP16_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= (w_gntIdx == c_ID_W'(NUM_REQ - 1)) ? '0 : (w_gntIdx + c_ID_W'(1));
            end
            if (w_accept && !w_pop) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register and tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mulIssue <= 1'b0;
            r_mulA     <= '0;
            r_mulB     <= '0;
            r_issueId  <= '0;
        end else begin
            r_mulIssue <= w_accept;
            if (w_accept) begin
                r_mulA    <= w_selA;
                r_mulB    <= w_selB;
                r_issueId <= w_gntIdx;
            end
        end
    end

    assign mul_issue = r_mulIssue;
    assign mul_a     = r_mulA;
    assign mul_b     = r_mulB;

    // The last stage lines up with the cycle in which the multiplier
    // presents the product for the matching issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tagValid <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                r_tagId[s] <= '0;
            end
        end else begin
            r_tagValid[0] <= r_mulIssue;
            r_tagId[0]    <= r_issueId;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagId[s]    <= r_tagId[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign w_push = r_tagValid[MUL_LATENCY-1];
    assign w_pop  = rsp_valid && rsp_ready;

    always_comb begin
        w_pushEntry                    = '0;
        w_pushEntry.id[c_ID_W-1:0]     = r_tagId[MUL_LATENCY-1];
        w_pushEntry.result             = mul_result;
        w_pushEntry.flags              = mul_flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Credits make a push into a full FIFO impossible unless the
            // head is leaving in the same cycle.
            assert (!(w_push && !w_pop && (r_fifoCnt == c_CNT_W'(FIFO_DEPTH))));
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + c_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_fifoCnt <= r_fifoCnt + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_fifoCnt <= r_fifoCnt - c_CNT_W'(1);
            end
        end
    end

    assign w_head     = r_mem[r_rdPtr];
    assign rsp_valid  = (r_fifoCnt != '0);
    assign rsp_id     = w_head.id[c_ID_W-1:0];
    assign rsp_result = w_head.result;
    assign rsp_flags  = w_head.flags;

    // Upper id bits are only meaningful for the widest requester count.
    assign w_unusedIdBits = ^w_head.id;

endmodule
`default_nettype wire
